// File: rtl/tx_shaper_pkg.sv
// Shared widths and the default root-raised-cosine tap set for the polyphase shaper.
// Pure declarations; no timing or flow-control behaviour of its own.
package tx_shaper_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Accumulator width: one signed coefficient grown by the NBAUD-term sum.
    function automatic int sw_width(input int cw, input int nbaud);
        return cw + clog2(nbaud) + 1;
    endfunction

    localparam logic signed [7:0] DEFAULT_COEF [24] = '{
        8'sh00, 8'shFE, 8'shFF, 8'sh00, 8'sh02, 8'sh00, 8'shFB, 8'shF5,
        8'shF9, 8'sh0A, 8'sh25, 8'sh3E, 8'sh48, 8'sh3E, 8'sh25, 8'sh0A,
        8'shF9, 8'shF5, 8'shFB, 8'sh00, 8'sh02, 8'sh00, 8'shFF, 8'shFE
    };

    function automatic logic signed [7:0] default_coef(input int k);
        logic [4:0] idx;
        idx = k[4:0];
        if (k >= 0 && k < 24) return DEFAULT_COEF[idx];
        return '0;
    endfunction

endpackage

// File: rtl/tx_polyphase_shaper_if.sv
// Symbol input, coefficient write port and sample output of the shaper.
// The symbol side has no stall: o_sym_ack tells the mapper when a bit was taken.
interface tx_polyphase_shaper_if
    import tx_shaper_pkg::*;
#(
    parameter int OS    = 4,
    parameter int NBAUD = 6,
    parameter int CW    = 8,
    parameter int OW    = 8
);
    localparam int N  = OS * NBAUD;
    localparam int AW = clog2(N);
    localparam int PW = clog2(OS);

    logic                 enable;
    logic                 i_sym_i;
    logic                 i_sym_q;
    logic                 o_sym_ack;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic signed [OW-1:0] o_i;
    logic signed [OW-1:0] o_q;
    logic                 o_valid;
    logic [PW-1:0]        o_phase;

    modport master (
        output enable, i_sym_i, i_sym_q, coef_we, coef_addr, coef_data,
        input  o_sym_ack, o_i, o_q, o_valid, o_phase
    );

    modport slave (
        input  enable, i_sym_i, i_sym_q, coef_we, coef_addr, coef_data,
        output o_sym_ack, o_i, o_q, o_valid, o_phase
    );

endinterface

// File: rtl/tx_shaper_channel.sv
// One rail of the shaper: symbol delay line, signed tap sum and saturation to OW bits.
// Sample registered one clk after enable; holds while enable is low (no backpressure).
module tx_shaper_channel
    import tx_shaper_pkg::*;
#(
    parameter int NBAUD = 6,
    parameter int CW    = 8,
    parameter int OW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 load,
    input  logic                 sym,
    input  logic signed [CW-1:0] tap [NBAUD],
    output logic signed [OW-1:0] sample
);
    localparam int SW = sw_width(CW, NBAUD);
    localparam logic signed [SW-1:0] MAXV = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic [NBAUD-1:0]     line;
    logic [NBAUD-1:0]     line_eff;
    logic signed [SW-1:0] sum;
    logic signed [OW-1:0] sat;

    // The symbol taken this cycle already contributes to this cycle's sample.
    assign line_eff = load ? {line[NBAUD-2:0], sym} : line;

    always_comb begin
        sum = '0;
        for (int k = 0; k < NBAUD; k++) begin
            if (line_eff[k]) sum = sum + SW'(tap[k]);
            else             sum = sum - SW'(tap[k]);
        end
    end

    always_comb begin
        sat = sum[OW-1:0];
        if (sum > MAXV)      sat = MAXV[OW-1:0];
        else if (sum < MINV) sat = MINV[OW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line   <= '0;
            sample <= '0;
        end else if (enable) begin
            line   <= line_eff;
            sample <= sat;
        end
    end

endmodule

// File: rtl/tx_polyphase_shaper.sv
// I/Q polyphase RRC interpolator: OS saturated samples per antipodal symbol per rail.
// One sample per enable, registered one clk later; symbols must be ready when acked.
module tx_polyphase_shaper
    import tx_shaper_pkg::*;
#(
    parameter int OS    = 4,
    parameter int NBAUD = 6,
    parameter int CW    = 8,
    parameter int OW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tx_polyphase_shaper_if.slave bus
);
    localparam int N  = OS * NBAUD;
    localparam int AW = clog2(N);
    localparam int PW = clog2(OS);
    localparam int FW = clog2(NBAUD + 1);

    logic [PW-1:0]        phase;
    logic [FW-1:0]        fill;
    logic [FW-1:0]        fill_next;
    logic                 sym_ack;
    logic signed [CW-1:0] h   [N];
    logic signed [CW-1:0] tap [NBAUD];

    assign sym_ack       = bus.enable && (phase == '0);
    assign bus.o_sym_ack = sym_ack;
    assign fill_next     = (sym_ack && fill != FW'(NBAUD)) ? fill + FW'(1) : fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            fill        <= '0;
            bus.o_phase <= '0;
            bus.o_valid <= 1'b0;
        end else begin
            bus.o_valid <= bus.enable && (fill_next == FW'(NBAUD));
            if (bus.enable) begin
                phase       <= (phase == PW'(OS - 1)) ? '0 : phase + PW'(1);
                fill        <= fill_next;
                bus.o_phase <= phase;
            end
        end
    end

    // Addresses past N-1 match no tap and are dropped.
    for (genvar t = 0; t < N; t++) begin : g_bank
        always_ff @(posedge clk) begin
            if (rst)
                h[t] <= CW'(default_coef(t));
            else if (bus.coef_we && bus.coef_addr == AW'(t))
                h[t] <= bus.coef_data;
        end
    end

    for (genvar k = 0; k < NBAUD; k++) begin : g_tap
        assign tap[k] = h[AW'(k * OS) + AW'(phase)];
    end

    tx_shaper_channel #(.NBAUD(NBAUD), .CW(CW), .OW(OW)) u_chan_i (
        .clk    (clk),
        .rst    (rst),
        .enable (bus.enable),
        .load   (sym_ack),
        .sym    (bus.i_sym_i),
        .tap    (tap),
        .sample (bus.o_i)
    );

    tx_shaper_channel #(.NBAUD(NBAUD), .CW(CW), .OW(OW)) u_chan_q (
        .clk    (clk),
        .rst    (rst),
        .enable (bus.enable),
        .load   (sym_ack),
        .sym    (bus.i_sym_q),
        .tap    (tap),
        .sample (bus.o_q)
    );

endmodule

// File: tb/tb_tx_polyphase_shaper.sv
// Randomized and directed bench for tx_polyphase_shaper against a symbol-history model.
module tb_tx_polyphase_shaper;
    localparam int OS = 4, NBAUD = 6, CW = 8, OW = 8, N = OS * NBAUD;
    localparam int DEF [24] = '{0, -2, -1, 0, 2, 0, -5, -11, -7, 10, 37, 62,
                                72, 62, 37, 10, -7, -11, -5, 0, 2, 0, -1, -2};
    localparam int PAT [4] = '{62, 59, 62, 59};

    logic clk = 1'b0;
    logic rst = 1'b1;

    tx_polyphase_shaper_if #(.OS(OS), .NBAUD(NBAUD), .CW(CW), .OW(OW)) bus ();
    tx_polyphase_shaper #(.OS(OS), .NBAUD(NBAUD), .CW(CW), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: coefficient copy, newest-first symbol history, sample count since reset.
    int mh [N];
    bit m_hi [$];
    bit m_hq [$];
    int m_cnt  = 0;
    int m_nsym = 0;
    int e_i = 0, e_q = 0, e_ph = 0, e_v = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int shape(input bit hq [$], input int p);
        int s;
        bit b;
        s = 0;
        for (int k = 0; k < NBAUD; k++) begin
            b = (k < hq.size()) ? hq[k] : 1'b0;
            s += b ? mh[k*OS + p] : -mh[k*OS + p];
        end
        return s;
    endfunction

    function automatic int sat(input int s);
        int hi, lo;
        hi = (1 << (OW - 1)) - 1;
        lo = -(1 << (OW - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    task automatic model_step(input bit en, input bit si, input bit sq, input bit we,
                              input int a, input int d, input bit r);
        int p;
        if (r) begin
            m_cnt = 0; m_nsym = 0;
            m_hi.delete(); m_hq.delete();
            for (int k = 0; k < N; k++) mh[k] = DEF[k];
            e_i = 0; e_q = 0; e_ph = 0; e_v = 0;
            return;
        end
        if (en) begin
            p = m_cnt % OS;
            if (p == 0) begin
                m_hi.push_front(si);
                m_hq.push_front(sq);
                m_nsym++;
                if (m_hi.size() > NBAUD) begin
                    void'(m_hi.pop_back());
                    void'(m_hq.pop_back());
                end
            end
            e_i  = sat(shape(m_hi, p));
            e_q  = sat(shape(m_hq, p));
            e_ph = p;
            e_v  = (m_nsym >= NBAUD) ? 1 : 0;
            m_cnt++;
        end else begin
            e_v = 0;
        end
        if (we && a < N) mh[a] = d;
    endtask

    task automatic cyc(input bit en, input bit si, input bit sq, input bit we,
                       input int a, input int d, input bit r);
        @(negedge clk);
        rst           = r;
        bus.enable    = en;
        bus.i_sym_i   = si;
        bus.i_sym_q   = sq;
        bus.coef_we   = we;
        bus.coef_addr = 5'(a);
        bus.coef_data = 8'(d);
        #1;
        if (!r) chk("o_sym_ack", int'(bus.o_sym_ack), (en && (m_cnt % OS == 0)) ? 1 : 0);
        model_step(en, si, sq, we, a, d, r);
        chk_on = 1'b1;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic run_to_valid(input string name);
        int first;
        first = 0;
        for (int n = 1; n <= 40; n++) begin
            cyc(1, 1, 0, 0, 0, 0, 0);
            settle();
            if (bus.o_valid === 1'b1) begin
                first = n;
                break;
            end
        end
        chk(name, first, 21);
    endtask

    task automatic ones_pattern(input int cnt, input int start_ph);
        int ph;
        for (int j = 0; j < cnt; j++) begin
            cyc(1, 1, 0, 0, 0, 0, 0);
            settle();
            ph = (start_ph + j) % 4;
            chk("pattern_i", int'(bus.o_i), PAT[ph]);
            chk("pattern_q", int'(bus.o_q), -PAT[ph]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("o_i", int'(bus.o_i), e_i);
            chk("o_q", int'(bus.o_q), e_q);
            chk("o_phase", int'(bus.o_phase), e_ph);
            chk("o_valid", int'(bus.o_valid), e_v);
        end
    end

    initial begin
        bus.enable = 0; bus.i_sym_i = 0; bus.i_sym_q = 0;
        bus.coef_we = 0; bus.coef_addr = '0; bus.coef_data = '0;

        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        settle();
        chk("reset_o_i", int'(bus.o_i), 0);
        chk("reset_o_q", int'(bus.o_q), 0);
        chk("reset_o_valid", int'(bus.o_valid), 0);
        chk("reset_o_phase", int'(bus.o_phase), 0);

        // Steady all-ones I / all-zeros Q with default taps.
        run_to_valid("first_valid_enables");
        ones_pattern(8, 1);

        // Mid-symbol stall: one sample at phase 1, then five idle clocks.
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int j = 0; j < 5; j++) cyc(0, 1, 0, 0, 0, 0, 0);
        settle();
        chk("hold_phase", int'(bus.o_phase), 1);
        chk("hold_valid", int'(bus.o_valid), 0);
        chk("hold_i", int'(bus.o_i), 59);
        chk("hold_q", int'(bus.o_q), -59);

        // Tap 12 rewritten in the same cycle as a phase-0 sample.
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 12, 0, 0);
        settle();
        chk("coef_same_cycle", int'(bus.o_i), 62);
        for (int j = 0; j < 3; j++) cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        settle();
        chk("coef_next_symbol", int'(bus.o_i), -10);

        // Reset mid-symbol after another tap write restores the defaults.
        cyc(0, 1, 0, 1, 11, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        run_to_valid("valid_after_rst");
        ones_pattern(4, 1);

        // Saturation with every tap at +127.
        for (int t = 0; t < N; t++) cyc(0, 0, 0, 1, t, 127, 0);
        for (int j = 0; j < 30; j++) cyc(1, 1, 1, 0, 0, 0, 0);
        settle();
        chk("sat_high_i", int'(bus.o_i), 127);
        chk("sat_high_q", int'(bus.o_q), 127);
        for (int j = 0; j < 30; j++) cyc(1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("sat_low_i", int'(bus.o_i), -128);

        // Single +1 on I in a stream of zeros, default taps.
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int j = 0; j < 8; j++) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        settle();
        chk("impulse_p0", int'(bus.o_i), -62);
        cyc(1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("impulse_p1", int'(bus.o_i), -63);
        cyc(1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("impulse_p2", int'(bus.o_i), -64);
        for (int j = 0; j < 28; j++) cyc(1, 0, $urandom_range(0, 1), 0, 0, 0, 0);

        // Random enables, symbols, tap writes (including out-of-range) and rare resets.
        for (int j = 0; j < 800; j++) begin
            cyc(($urandom % 4) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                ($urandom % 8) == 0, $urandom_range(0, 31),
                int'($urandom_range(0, 255)) - 128, ($urandom % 250) == 0);
        end
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_polyphase_shaper.md
# tx_polyphase_shaper

Parametrised two-channel (I/Q) polyphase pulse-shaping interpolator for the QPSK transmitter. It sits between the symbol mapper and the DAC/upconversion path. Each channel takes one antipodal bit per symbol (1 → +1, 0 → −1) and outputs OS saturated signed samples per symbol. The outputs are filtered through a runtime-loadable coefficient bank that resets to the default root-raised-cosine set.

## Interface
- OS, 4: oversampling factor (samples per symbol), ≥2
- NBAUD, 6: filter span in symbols; taps N = OS*NBAUD
- CW, 8: coefficient width, signed
- OW, 8: output width, signed, OW ≤ SW where SW = CW + clog2(NBAUD) + 1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  sample-rate tick; one output sample per enable
- i_sym_i  in  1  I symbol bit, sampled when o_sym_ack=1
- i_sym_q  in  1  Q symbol bit, sampled when o_sym_ack=1
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(N)  tap index 0..N−1
- coef_data  in  CW  signed coefficient
- o_sym_ack  out  1  combinational: enable && phase==0; symbol captured this cycle
- o_i  out  OW  I output sample, registered
- o_q  out  OW  Q output sample, registered
- o_valid  out  1  registered; one-cycle pulse per output sample once the delay line is full
- o_phase  out  clog2(OS)  phase index of the sample currently on o_i/o_q

## Operation
- Phase counter p: 0..OS−1. It increments on each enable and wraps from OS−1 to 0.
- Symbol delay line per channel: b[0..NBAUD−1], where b[0] is the newest symbol.
  - Effective line b' = (p==0) ? {b[NBAUD−2:0], sym} : b.
  - b <= b' on enable.
- Sample computation: sum = Σk=0..NBAUD−1 (b'[k] ? +h[k*OS+p] : −h[k*OS+p]), evaluated in SW bits.
- Saturation to OW bits:
  - sum > 2^(OW−1)−1 → 2^(OW−1)−1
  - sum < −2^(OW−1) → −2^(OW−1)
  - otherwise sum[OW−1:0]
- On enable: o_i/o_q <= saturated sums, o_phase <= p, and o_valid <= (fill==NBAUD after this capture).
- Without enable: o_i, o_q, o_phase and b hold, and o_valid <= 0.
- Fill counter: increments on each o_sym_ack and saturates at NBAUD.
- Coefficient bank h[0..N−1]: one register per tap, shared by I and Q.
  - A coef_we write takes effect the following cycle.
  - If coef_we and enable occur in the same cycle, that sample uses the old value.
  - An out-of-range coef_addr (N when N is not a power of two) is ignored.
- Reset (any time, including mid-symbol):
  - p, b, fill = 0
  - o_i, o_q, o_phase, o_valid = 0
  - h reloaded from DEFAULT_COEF
  - rst overrides enable and coef_we.

## Timing
- Latency: a symbol captured at enable E contributes to the output visible one clk after E, at phase 0. Its last contribution is at the (OS*NBAUD)-th sample after capture.
- Throughput: one sample per enable. Back-to-back enable every clk is legal.
- o_sym_ack is combinational from enable and p. The upstream must present the symbol in the same cycle; no stall is supported.
- First o_valid: on the enable that captures the NBAUD-th symbol after reset. That is 1 + (NBAUD−1)*OS enables after reset (21 for the defaults).

## Structure
- Package tx_shaper_pkg contains:
  - the clog2 function
  - the SW width function
  - DEFAULT_COEF, 24×8 for OS=4/NBAUD=6: 00 FE FF 00 02 00 FB F5 F9 0A 25 3E 48 3E 25 0A F9 F5 FB 00 02 00 FF FE
- Sub-module tx_shaper_channel: delay line, adder tree and saturation for one channel. It is instantiated twice.
- The top level owns the phase counter, fill counter, coefficient bank and o_valid.

## Test plan
- Reset → o_i=o_q=0, o_valid=0, o_phase=0, o_sym_ack=1 on the first enable.
- Default coefs, I all-ones, Q all-zeros, enable every clk → after first o_valid, o_i cycles 62,59,62,59 and o_q cycles −62,−59,−62,−59 for phases 0..3.
- Load all 24 coefs with 0x7F, then all-ones → o_i=127; all-zeros → o_i=−128 (saturation).
- Default coefs, zeros stream with a single 1 on I → o_i per sample equals −62/−59 plus 2*h[k*4+p] for the tap aligned with the 1. Matches the reference model for all 24 samples.
- Write coef_addr=12 with 0x00 in the same cycle as an enable at p=0 → that sample uses 72; the next p=0 sample uses 0.
- Enable deasserted for 5 clks mid-symbol → outputs and o_phase hold, o_valid=0. Assert rst mid-stream after a coef write → defaults restored, o_valid stays 0 until 21 enables.
